// File: rtl/bht_lookup_unit.sv
// Branch history table of 2-bit saturating counters, swept to 2'b01 after reset; BHT_LOOKUP_UNIT_BYPASS_EN forwards a same-cycle same-index update into the lookup.
// Latency 1 cycle, throughput 1/cycle; req_rdy drops during the init sweep and while a response is stalled (resp_val && !resp_rdy).
module bht_lookup_unit #(
  parameter int p_idx_nbits = 6
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_val,
  output logic        req_rdy,
  input  logic [31:0] req_pc,
  output logic        resp_val,
  input  logic        resp_rdy,
  output logic        resp_taken,
  output logic [1:0]  resp_ctr,
  input  logic        upd_en,
  input  logic [31:0] upd_pc,
  input  logic        upd_taken,
  output logic        init_done
);

  typedef enum logic {ST_INIT, ST_RUN} state_e;

  localparam int c_depth = 1 << p_idx_nbits;
  localparam logic [p_idx_nbits-1:0] c_idx_max = '1;
  localparam logic [p_idx_nbits-1:0] c_idx_one = {{(p_idx_nbits-1){1'b0}}, 1'b1};

  state_e                 state_q, state_d;
  logic [p_idx_nbits-1:0] ptr_q, ptr_d;
  logic                   resp_val_q, resp_val_d;
  logic [1:0]             resp_ctr_q, resp_ctr_d;
  logic [1:0]             tbl_q [c_depth];
  logic [1:0]             tbl_d [c_depth];

  logic                   run;
  logic                   fire;
  logic [p_idx_nbits-1:0] req_idx, upd_idx;
  logic [1:0]             upd_old, upd_new, rd_ctr;

  assign req_idx = req_pc[p_idx_nbits+1:2];
  assign upd_idx = upd_pc[p_idx_nbits+1:2];

  logic unused_pc_bits;
  assign unused_pc_bits = ^{req_pc[31:p_idx_nbits+2], req_pc[1:0],
                            upd_pc[31:p_idx_nbits+2], upd_pc[1:0]};

  assign run        = (state_q == ST_RUN);
  assign init_done  = run;
  assign req_rdy    = run && (!resp_val_q || resp_rdy);
  assign fire       = req_val && req_rdy;
  assign resp_val   = resp_val_q;
  assign resp_ctr   = resp_ctr_q;
  assign resp_taken = resp_ctr_q[1];

  // The init sweep walks every index once, then hands over to RUN.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    if (state_q == ST_INIT) begin
      ptr_d = ptr_q + c_idx_one;
      if (ptr_q == c_idx_max) begin
        state_d = ST_RUN;
      end
    end
  end

  always_comb begin
    upd_old = tbl_q[upd_idx];
    upd_new = upd_old;
    if (upd_taken) begin
      if (upd_old != 2'b11) upd_new = upd_old + 2'd1;
    end else begin
      if (upd_old != 2'b00) upd_new = upd_old - 2'd1;
    end

    tbl_d = tbl_q;
    if (!run) begin
      tbl_d[ptr_q] = 2'b01;
    end else if (upd_en) begin
      tbl_d[upd_idx] = upd_new;
    end

    rd_ctr = tbl_q[req_idx];
`ifdef BHT_LOOKUP_UNIT_BYPASS_EN
    if (run && upd_en && (upd_idx == req_idx)) begin
      rd_ctr = upd_new;
    end
`endif
  end

  // A stalled response is captured in its own register, so later updates cannot disturb it.
  always_comb begin
    resp_val_d = resp_val_q;
    resp_ctr_d = resp_ctr_q;
    if (fire) begin
      resp_val_d = 1'b1;
      resp_ctr_d = rd_ctr;
    end else if (resp_rdy) begin
      resp_val_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_INIT;
      ptr_q      <= '0;
      resp_val_q <= 1'b0;
      resp_ctr_q <= 2'b00;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      resp_val_q <= resp_val_d;
      resp_ctr_q <= resp_ctr_d;
    end
  end

  always_ff @(posedge clk) begin
    tbl_q <= tbl_d;
  end

endmodule
